// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// The transmitter imports the same package so both ends agree on the defaults.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer for asynchronous inputs.
// Resets to 1 so an idle-high serial line does not look like an edge.
module sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with a one-entry valid/ready output register.
// Frame timing advances only on os_tick; the output handshake runs on every clk.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  deliver;
    logic                  frame_err_d;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // START checks the line half a bit in, so every later sample lands mid-bit.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        if (os_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rx_s) begin
                            deliver = 1'b1;
                            state_d = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // A delivery may reuse the slot only if the consumer drains it in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-serially at 64 clk per bit,
// expected events are queued at issue time and matched by an independent monitor.
module tb_uart_rx;

    localparam int DATA_BITS = 8;
    localparam int OS        = 16;
    localparam int BIT_CLKS  = OS * 4;

    logic                 clk;
    logic                 rst;
    logic                 os_tick;
    logic                 rx;
    logic                 rx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 overrun;

    typedef enum int {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    bit  model_full = 1'b0;
    int  cyc        = 0;
    int  num_checks = 0;
    int  num_fails  = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .os_tick  (os_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // os_tick is high in the cycle after every posedge whose count is a multiple of 4.
    initial begin
        os_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            os_tick = (cyc % 4 == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic popExpected(input ev_kind_t kind, input logic [7:0] data, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL %s: got unexpected event kind %0d data 0x%0h, expected none",
                     name, kind, data);
        end else begin
            e = exp_q.pop_front();
            checkOutput({name, " kind"}, kind, e.kind);
            if (kind == EV_DATA && e.kind == EV_DATA) begin
                checkOutput({name, " data"}, data, e.data);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic alignFrame();
        do begin
            waitCycles(1);
        end while (cyc % 4 != 2);
    endtask

    // Reference model: what the receiver must report for this frame given the
    // consumer's readiness and whether the output slot is already occupied.
    task automatic predictFrame(input logic [7:0] data, input logic stop_bit, input bit ready_pulse);
        if (!stop_bit) begin
            exp_q.push_back('{kind: EV_FERR, data: 8'h00});
        end else if (!model_full || rx_ready || ready_pulse) begin
            exp_q.push_back('{kind: EV_DATA, data: data});
            model_full = !rx_ready;
        end else begin
            exp_q.push_back('{kind: EV_OVR, data: 8'h00});
        end
    endtask

    // The start edge is launched 2 clk before an os_tick is sampled, which puts the
    // stop-bit centre tick at posedge n0+611; ready_pulse raises rx_ready for exactly that cycle.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input bit ready_pulse);
        int n0;
        predictFrame(data, stop_bit, ready_pulse);
        alignFrame();
        n0 = cyc;
        rx = 1'b0;
        waitCycles(BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = data[i];
            waitCycles(BIT_CLKS);
        end
        rx = stop_bit;
        if (ready_pulse) begin
            waitCycles(n0 + 610 - cyc);
            rx_ready = 1'b1;
            waitCycles(1);
            rx_ready = 1'b0;
            waitCycles(n0 + 640 - cyc);
        end else begin
            waitCycles(BIT_CLKS);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
            end else begin
                if (frame_err || overrun) begin
                    checkOutput("flags exclusive", 32'(frame_err && overrun), 32'd0);
                end
                if (frame_err) begin
                    popExpected(EV_FERR, 8'h00, "frame_err");
                end
                if (overrun) begin
                    popExpected(EV_OVR, 8'h00, "overrun");
                end
                if (rx_valid && (!prev_valid || prev_ready)) begin
                    popExpected(EV_DATA, rx_data, "byte");
                end
                prev_valid = rx_valid;
                prev_ready = rx_ready;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit expiry, expected test completion");
        num_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        waitCycles(5);
        @(negedge clk);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        waitCycles(1);
        rst = 1'b0;
        waitCycles(20);

        $display("[TB] single frame 0xA5");
        rx_ready = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitCycles(100);

        $display("[TB] start-bit glitch");
        alignFrame();
        rx = 1'b0;
        waitCycles(16);
        rx = 1'b1;
        waitCycles(2 * BIT_CLKS);

        $display("[TB] framing error then held-low line");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitCycles(3 * BIT_CLKS);
        rx = 1'b1;
        waitCycles(BIT_CLKS);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        waitCycles(100);

        $display("[TB] overrun with consumer stalled");
        rx_ready = 1'b0;
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        waitCycles(20);
        checkOutput("stalled rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("stalled rx_data", 32'(rx_data), 32'h11);
        rx_ready   = 1'b1;
        model_full = 1'b0;
        waitCycles(1);
        rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("accept rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("accept rx_data", 32'(rx_data), 32'h11);
        waitCycles(20);

        $display("[TB] accept in delivery cycle");
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b1);
        waitCycles(10);
        checkOutput("same-cycle rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("same-cycle rx_data", 32'(rx_data), 32'h22);
        rx_ready   = 1'b1;
        model_full = 1'b0;
        waitCycles(2);
        checkOutput("drain rx_valid", 32'(rx_valid), 32'd0);

        $display("[TB] reset mid-frame then loopback bytes");
        rx_ready = 1'b0;
        applyStimulus(8'h77, 1'b1, 1'b0);
        waitCycles(10);
        alignFrame();
        rx = 1'b0;
        waitCycles(3 * BIT_CLKS + 10);
        rx  = 1'b1;
        rst = 1'b1;
        waitCycles(3);
        @(negedge clk);
        checkOutput("mid-frame reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("mid-frame reset rx_data", 32'(rx_data), 32'd0);
        waitCycles(1);
        rst        = 1'b0;
        model_full = 1'b0;
        rx_ready   = 1'b1;
        waitCycles(BIT_CLKS);
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0);
        waitCycles(100);

        $display("[TB] randomized frames");
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            logic       stop_ok;
            b       = 8'($urandom_range(0, 255));
            stop_ok = ($urandom_range(0, 3) != 0);
            applyStimulus(b, stop_ok, 1'b0);
            rx = 1'b1;
            waitCycles(10 + $urandom_range(0, 80));
        end
        waitCycles(200);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
